silife_scan_capture: RTL and testbench

SILIFE_SCAN_CAPTURE -- requirements
Module: silife_scan_capture

---
 rtl/silife_pkg.sv | 28 ++
 rtl/silife_onehot_decode.sv | 28 ++
 rtl/silife_scan_capture.sv | 148 ++++++++++++++
 tb/tb_silife_scan_capture.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/silife_pkg.sv
// Shared definitions for the silife scan-capture block: grid size,
// row index type, capture FSM states and small arithmetic helpers.
package silife_pkg;

    localparam int GRID_SIZE = 8;
    localparam int ROW_W     = 3;

    typedef logic [ROW_W-1:0] row_idx_t;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_COMMIT  = 2'd2
    } cap_state_t;

    localparam row_idx_t ROW_FIRST = 3'd0;

    // Row that must follow r in a scan; row 7 wraps back to row 0.
    function automatic row_idx_t next_row(input row_idx_t r);
        return r + 3'd1;
    endfunction

    // Saturating increment for the dwell counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/silife_onehot_decode.sv
// Decodes the polarity-corrected row-select lines into a row index,
// a "exactly one line high" flag and a "several lines high" flag.
// All-zero lines (blanking) give valid_o = 0 and multi_o = 0.
module silife_onehot_decode
    import silife_pkg::*;
(
    input  logic [GRID_SIZE-1:0] line_i,
    output row_idx_t             idx_o,
    output logic                 valid_o,
    output logic                 multi_o
);

    logic [3:0] count_s;

    // Population count and index of the set line (OR of indices is exact when one-hot).
    always_comb begin
        count_s = 4'd0;
        idx_o   = ROW_FIRST;
        for (int i = 0; i < GRID_SIZE; i++) begin
            count_s = count_s + {3'b000, line_i[i]};
            idx_o   = idx_o | (line_i[i] ? row_idx_t'(i) : ROW_FIRST);
        end
    end

    assign valid_o = (count_s == 4'd1);
    assign multi_o = (count_s > 4'd1);

endmodule

// File: rtl/silife_scan_capture.sv
// Captures an 8x8 frame from a row-scanned display bus. Rows must appear
// in order 0..7, each held for 'cycles' clocks; blanking (no row) is
// transparent. A complete, correctly timed frame is committed to 'cells'
// on the first clock of the following row 0.
module silife_scan_capture
    import silife_pkg::*;
(
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            invert,
    input  logic [15:0]                     cycles,
    input  logic [GRID_SIZE-1:0]            rows,
    input  logic [GRID_SIZE-1:0]            columns,
    output logic [GRID_SIZE-1:0][GRID_SIZE-1:0] cells,
    output logic                            frame_valid,
    output logic                            sync_error,
    output logic                            timing_error
);

    logic [GRID_SIZE-1:0] rows_s;
    logic [GRID_SIZE-1:0] cols_s;
    row_idx_t             row_idx_s;
    logic                 row_valid_s;
    logic                 row_multi_s;
    logic [15:0]          cycles_eff_s;

    cap_state_t                          state_q,        state_d;
    row_idx_t                            cur_row_q,      cur_row_d;
    logic [15:0]                         dwell_q,        dwell_d;
    logic [GRID_SIZE-1:0][GRID_SIZE-1:0] shadow_q,       shadow_d;
    logic [GRID_SIZE-1:0][GRID_SIZE-1:0] cells_q,        cells_d;
    logic                                frame_valid_q,  frame_valid_d;
    logic                                sync_error_q,   sync_error_d;
    logic                                timing_error_q, timing_error_d;

    assign rows_s       = rows    ^ {GRID_SIZE{invert}};
    assign cols_s       = columns ^ {GRID_SIZE{invert}};
    assign cycles_eff_s = (cycles == 16'd0) ? 16'd1 : cycles;

    silife_onehot_decode u_decode (
        .line_i  (rows_s),
        .idx_o   (row_idx_s),
        .valid_o (row_valid_s),
        .multi_o (row_multi_s)
    );

    // Next-state logic: row sequencing, dwell checking, shadow capture and commit.
    always_comb begin
        // COMMIT lasts one clock and then behaves as capture of row 0.
        state_d        = (state_q == ST_COMMIT) ? ST_CAPTURE : state_q;
        cur_row_d      = cur_row_q;
        dwell_d        = dwell_q;
        shadow_d       = shadow_q;
        cells_d        = cells_q;
        frame_valid_d  = 1'b0;
        sync_error_d   = 1'b0;
        timing_error_d = 1'b0;

        if (row_multi_s) begin
            // Several rows at once is a sync violation in every state.
            sync_error_d = 1'b1;
            state_d      = ST_HUNT;
            cur_row_d    = ROW_FIRST;
            dwell_d      = 16'd0;
            shadow_d     = '0;
        end else if (row_valid_s) begin
            case (state_q)
                ST_HUNT: begin
                    if (row_idx_s == ROW_FIRST) begin
                        state_d             = ST_CAPTURE;
                        cur_row_d           = ROW_FIRST;
                        dwell_d             = 16'd1;
                        shadow_d[ROW_FIRST] = cols_s;
                    end else begin
                        // Any other row is ignored while hunting.
                        dwell_d = dwell_q;
                    end
                end
                ST_CAPTURE, ST_COMMIT: begin
                    if (row_idx_s == cur_row_q) begin
                        dwell_d = sat_inc16(dwell_q);
                    end else if (row_idx_s == next_row(cur_row_q)) begin
                        if (dwell_q != cycles_eff_s) begin
                            timing_error_d = 1'b1;
                            state_d        = ST_HUNT;
                            cur_row_d      = ROW_FIRST;
                            dwell_d        = 16'd0;
                            shadow_d       = '0;
                        end else begin
                            if (row_idx_s == ROW_FIRST) begin
                                // Row 0 after a good row 7: publish the frame.
                                cells_d       = shadow_q;
                                frame_valid_d = 1'b1;
                                state_d       = ST_COMMIT;
                            end else begin
                                state_d = ST_CAPTURE;
                            end
                            cur_row_d           = row_idx_s;
                            dwell_d             = 16'd1;
                            shadow_d[row_idx_s] = cols_s;
                        end
                    end else begin
                        sync_error_d = 1'b1;
                        state_d      = ST_HUNT;
                        cur_row_d    = ROW_FIRST;
                        dwell_d      = 16'd0;
                        shadow_d     = '0;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end else begin
            // Blanking: nothing captured, dwell frozen.
            dwell_d = dwell_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_HUNT;
            cur_row_q      <= ROW_FIRST;
            dwell_q        <= 16'd0;
            shadow_q       <= '0;
            cells_q        <= '0;
            frame_valid_q  <= 1'b0;
            sync_error_q   <= 1'b0;
            timing_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_row_q      <= cur_row_d;
            dwell_q        <= dwell_d;
            shadow_q       <= shadow_d;
            cells_q        <= cells_d;
            frame_valid_q  <= frame_valid_d;
            sync_error_q   <= sync_error_d;
            timing_error_q <= timing_error_d;
        end
    end

    assign cells        = cells_q;
    assign frame_valid  = frame_valid_q;
    assign sync_error   = sync_error_q;
    assign timing_error = timing_error_q;

endmodule

// File: tb/tb_silife_scan_capture.sv
// Bench for silife_scan_capture: directed scenarios plus randomized scans,
// all compared every cycle against a behavioural frame model.
module tb_silife_scan_capture;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             invert;
    logic [15:0]      cycles;
    logic [7:0]       rows;
    logic [7:0]       columns;
    logic [7:0][7:0]  cells;
    logic             frame_valid;
    logic             sync_error;
    logic             timing_error;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    silife_scan_capture dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .invert       (invert),
        .cycles       (cycles),
        .rows         (rows),
        .columns      (columns),
        .cells        (cells),
        .frame_valid  (frame_valid),
        .sync_error   (sync_error),
        .timing_error (timing_error)
    );

    // Behavioural model: m_cur = row being held (-1 = not locked to a frame).
    int              m_cur  = -1;
    int              m_held = 0;
    logic [7:0][7:0] m_frame = '0;
    logic [7:0][7:0] m_cells = '0;
    logic            m_fv = 1'b0, m_se = 1'b0, m_te = 1'b0;
    logic            chk_en = 1'b0;
    int              cyc_n = 0;
    int              fv_cnt = 0, se_cnt = 0, te_cnt = 0;
    int              fv_stamp[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Model update on every rising edge from the lines the DUT sees.
    initial begin : model_proc
        logic [7:0] r;
        logic [7:0] c;
        int k;
        int eff;
        forever begin
            @(posedge clk);
            cyc_n++;
            r   = rows ^ {8{invert}};
            c   = columns ^ {8{invert}};
            eff = (cycles == 16'd0) ? 1 : int'(cycles);
            m_fv = 1'b0; m_se = 1'b0; m_te = 1'b0;
            if (reset_n !== 1'b1) begin
                m_cur = -1; m_held = 0; m_cells = '0; m_frame = '0;
            end else if ($countones(r) > 1) begin
                m_se = 1'b1; m_cur = -1;
            end else if (r != 8'h00) begin
                k = 0;
                for (int i = 0; i < 8; i++) if (r[i]) k = i;
                if (m_cur < 0) begin
                    if (k == 0) begin m_cur = 0; m_held = 1; m_frame[0] = c; end
                end else if (k == m_cur) begin
                    if (m_held < 65535) m_held++;
                end else if (k == (m_cur + 1) % 8) begin
                    if (m_held != eff) begin
                        m_te = 1'b1; m_cur = -1;
                    end else begin
                        if (k == 0) begin m_cells = m_frame; m_fv = 1'b1; end
                        m_cur = k; m_held = 1; m_frame[k] = c;
                    end
                end else begin
                    m_se = 1'b1; m_cur = -1;
                end
            end
        end
    end

    // Compare process: DUT outputs against the model on every falling edge.
    initial begin : compare_proc
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("frame_valid", {63'd0, frame_valid}, {63'd0, m_fv});
                check("sync_error", {63'd0, sync_error}, {63'd0, m_se});
                check("timing_error", {63'd0, timing_error}, {63'd0, m_te});
                check("cells", cells, m_cells);
                if (frame_valid === 1'b1) begin fv_cnt++; fv_stamp.push_back(cyc_n); end
                if (sync_error === 1'b1) se_cnt++;
                if (timing_error === 1'b1) te_cnt++;
            end
        end
    end

    // Drive one clock of polarity-corrected row/column values.
    task automatic tick(input logic [7:0] r, input logic [7:0] c);
        @(negedge clk);
        rows    = r ^ {8{invert}};
        columns = c ^ {8{invert}};
    endtask

    task automatic sync_pt();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_row(input int k, input logic [7:0] c, input int n);
        logic [7:0] one;
        one = 8'h01;
        repeat (n) tick(one << k, c);
    endtask

    task automatic send_frame(input logic [7:0][7:0] f, input int n, input int blanks, input int long_row);
        for (int k = 0; k < 8; k++) begin
            hold_row(k, f[k], (k == long_row) ? n + 1 : n);
            repeat (blanks) tick(8'h00, 8'h5a);
        end
    endtask

    // First clock of the next row 0 must raise frame_valid one clock later.
    task automatic close_frame(input logic [7:0] c0);
        tick(8'h01, c0);
        sync_pt();
        check("fv_latency", {63'd0, frame_valid}, 64'd1);
        tick(8'h00, 8'h00);
        tick(8'h00, 8'h00);
        sync_pt();
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset_n = 1'b0;
        rows    = 8'h00 ^ {8{invert}};
        columns = 8'h00;
        repeat (n - 1) @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        fv_cnt = 0; se_cnt = 0; te_cnt = 0;
        fv_stamp.delete();
    endtask

    localparam logic [63:0] FRAME_A = 64'haa66_0024_0000_0020;
    localparam logic [63:0] FRAME_B = 64'h0123_4567_89ab_cdef;

    initial begin : stim_proc
        logic [7:0][7:0] fa;
        logic [7:0][7:0] fb;
        logic [7:0]      one;
        logic [7:0]      rv;
        logic [7:0]      cv;
        int              n;
        int              sel;

        fa = FRAME_A;
        fb = FRAME_B;
        one = 8'h01;
        reset_n = 1'b0; invert = 1'b0; cycles = 16'd3; rows = 8'h00; columns = 8'h00;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        sync_pt();
        check("reset_cells", cells, 64'd0);
        check("reset_pulses", {61'd0, frame_valid, sync_error, timing_error}, 64'd0);

        // Normal frames, true polarity.
        do_reset(2);
        repeat (4) send_frame(fa, 3, 0, -1);
        close_frame(fa[0]);
        check("s1_fv_count", 64'(fv_cnt), 64'd4);
        for (int i = 1; i < fv_stamp.size(); i++)
            check("s1_fv_period", 64'(fv_stamp[i] - fv_stamp[i-1]), 64'd24);
        check("s1_cells", cells, FRAME_A);
        check("model_pin_cells", m_cells, FRAME_A);

        // Same frames with inverted line polarity.
        invert = 1'b1;
        do_reset(2);
        repeat (4) send_frame(fa, 3, 0, -1);
        close_frame(fa[0]);
        check("s2_fv_count", 64'(fv_cnt), 64'd4);
        for (int i = 1; i < fv_stamp.size(); i++)
            check("s2_fv_period", 64'(fv_stamp[i] - fv_stamp[i-1]), 64'd24);
        check("s2_cells", cells, FRAME_A);
        invert = 1'b0;

        // Row 3 held one clock too long.
        do_reset(2);
        send_frame(fa, 3, 0, -1);
        send_frame(fb, 3, 0, 3);
        sync_pt();
        check("s3_te_count", 64'(te_cnt), 64'd1);
        check("s3_fv_count_mid", 64'(fv_cnt), 64'd1);
        check("s3_cells_held", cells, FRAME_A);
        send_frame(fb, 3, 0, -1);
        send_frame(fb, 3, 0, -1);
        close_frame(fb[0]);
        check("s3_fv_count", 64'(fv_cnt), 64'd3);
        check("s3_te_total", 64'(te_cnt), 64'd1);
        check("s3_cells", cells, FRAME_B);

        // Row sequence 0,1,3 then a multi-hot rows value.
        do_reset(2);
        hold_row(0, 8'h11, 3);
        hold_row(1, 8'h22, 3);
        tick(8'h08, 8'h33);
        sync_pt();
        check("s4_se_row3", {62'd0, sync_error, timing_error}, 64'd2);
        hold_row(3, 8'h33, 2);
        for (int k = 4; k < 8; k++) hold_row(k, 8'h44, 3);
        hold_row(0, 8'h55, 3);
        tick(8'h11, 8'h66);
        sync_pt();
        check("s4_se_multi", {63'd0, sync_error}, 64'd1);
        for (int k = 1; k < 8; k++) hold_row(k, 8'h77, 3);
        send_frame(fa, 3, 0, -1);
        close_frame(fa[0]);
        check("s4_se_count", 64'(se_cnt), 64'd2);
        check("s4_te_count", 64'(te_cnt), 64'd0);
        check("s4_fv_count", 64'(fv_cnt), 64'd1);

        // Reset for one clock during row 5.
        do_reset(2);
        send_frame(fb, 3, 0, -1);
        for (int k = 0; k < 5; k++) hold_row(k, fa[k], 3);
        hold_row(5, fa[5], 1);
        sync_pt();
        check("s5_fv_before", 64'(fv_cnt), 64'd1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        fv_cnt = 0; se_cnt = 0; te_cnt = 0;
        sync_pt();
        check("s5_cells_cleared", cells, 64'd0);
        check("s5_pulses_quiet", {61'd0, frame_valid, sync_error, timing_error}, 64'd0);
        hold_row(5, fa[5], 1);
        hold_row(6, fa[6], 3);
        hold_row(7, fa[7], 3);
        send_frame(fa, 3, 0, -1);
        close_frame(fa[0]);
        check("s5_fv_count", 64'(fv_cnt), 64'd1);
        check("s5_err_count", 64'(se_cnt + te_cnt), 64'd0);
        check("s5_cells", cells, FRAME_A);

        // Two blanking clocks between rows.
        do_reset(2);
        repeat (3) send_frame(fb, 3, 2, -1);
        close_frame(fb[0]);
        check("s6_fv_count", 64'(fv_cnt), 64'd3);
        check("s6_err_count", 64'(se_cnt + te_cnt), 64'd0);

        // cycles = 0 behaves as one clock per row.
        cycles = 16'd0;
        do_reset(2);
        repeat (2) send_frame(fa, 1, 0, -1);
        close_frame(fa[0]);
        check("s7_fv_count", 64'(fv_cnt), 64'd2);
        check("s7_err_count", 64'(se_cnt + te_cnt), 64'd0);

        // Randomized scans with occasional violations.
        for (int f = 0; f < 150; f++) begin
            invert = 1'($urandom_range(0, 1));
            cycles = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) do_reset(1);
            for (int k = 0; k < 8; k++) begin
                n = (cycles == 16'd0) ? 1 : int'(cycles);
                sel = $urandom_range(0, 59);
                if (sel == 0) n = n + 1;
                if (sel == 1 && n > 1) n = n - 1;
                rv = one << k;
                if (sel == 2) rv = one << ((k + 2) % 8);
                if (sel == 3) rv = rv | (one << ((k + 3) % 8));
                cv = 8'($urandom_range(0, 255));
                repeat (n) tick(rv, cv);
                if (sel == 4) begin
                    @(negedge clk);
                    invert = ~invert;
                end
                repeat ($urandom_range(0, 1)) tick(8'h00, 8'($urandom_range(0, 255)));
            end
        end
        repeat (3) tick(8'h00, 8'h00);
        sync_pt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
